// File: rtl/alu_operand_stage.sv
// ============================================================================
// alu_operand_stage
//
// Operand preparation stage in front of the RV32I ALU. Accepts an instruction
// word and PC, reads rs1/rs2 from a synchronous-read register file, decodes
// the instruction and presents fully prepared operands A/B plus an ALU
// operation code behind a valid/ready handshake. Immediate selection, sign
// extension and shift-amount masking all happen here, so the ALU only ever
// computes "A op B".
//
// Optional feature (macro OPERAND_FWD_EN): adds a write-back bypass port
// (wb_en_i / wb_addr_i / wb_data_i). When defined, a matching non-zero
// write-back address overrides the register-file data for rs1/rs2 at capture
// time. Without the macro the ports are absent.
//
// Ports:
//   clk_i, reset_i        clock (rising edge), asynchronous active-high reset
//   valid_i / ready_o     request handshake from the control matrix
//   ir_i, pc_i            instruction word and PC, sampled on acceptance
//   rf_rd_en_o            register file read strobe (one cycle)
//   rf_rs1_o, rf_rs2_o    register file read indices
//   rf_data1_i/2_i        register file read data, one cycle after the strobe
//   a_o, b_o              prepared ALU operands
//   func_op_o             ALU operation
//   rd_o                  destination register index passthrough
//   illegal_o             instruction not decodable by this stage
//   op_valid_o/op_ready_i output handshake towards the ALU
//   wb_en_i/wb_addr_i/wb_data_i  write-back bypass (OPERAND_FWD_EN only)
// ============================================================================

package alu_operand_pkg;
    typedef enum logic [3:0] {
        AddOp  = 4'd0,
        SubOp  = 4'd1,
        SllOp  = 4'd2,
        SltOp  = 4'd3,
        SltuOp = 4'd4,
        XorOp  = 4'd5,
        SrlOp  = 4'd6,
        SraOp  = 4'd7,
        OrOp   = 4'd8,
        AndOp  = 4'd9
    } ALU_Ops;
endpackage

module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RF_ADDR_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [DATA_WIDTH-1:0]    ir_i,
    input  logic [DATA_WIDTH-1:0]    pc_i,
    output logic                     rf_rd_en_o,
    output logic [RF_ADDR_WIDTH-1:0] rf_rs1_o,
    output logic [RF_ADDR_WIDTH-1:0] rf_rs2_o,
    input  logic [DATA_WIDTH-1:0]    rf_data1_i,
    input  logic [DATA_WIDTH-1:0]    rf_data2_i,
`ifdef OPERAND_FWD_EN
    input  logic                     wb_en_i,
    input  logic [RF_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
`endif
    output logic [DATA_WIDTH-1:0]    a_o,
    output logic [DATA_WIDTH-1:0]    b_o,
    output ALU_Ops                   func_op_o,
    output logic [RF_ADDR_WIDTH-1:0] rd_o,
    output logic                     illegal_o,
    output logic                     op_valid_o,
    input  logic                     op_ready_i
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    state_e                   r_state;
    logic [DATA_WIDTH-1:0]    r_ir;
    logic [DATA_WIDTH-1:0]    r_pc;
    logic                     r_rd_en;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    ALU_Ops                   r_op;
    logic [RF_ADDR_WIDTH-1:0] r_rd;
    logic                     r_illegal;
    logic                     r_op_valid;

    logic [RF_ADDR_WIDTH-1:0] w_rs1_idx;
    logic [RF_ADDR_WIDTH-1:0] w_rs2_idx;
    logic [DATA_WIDTH-1:0]    w_rs1_src;
    logic [DATA_WIDTH-1:0]    w_rs2_src;
    logic [DATA_WIDTH-1:0]    w_rs1;
    logic [DATA_WIDTH-1:0]    w_rs2;
    logic [6:0]               w_opcode;
    logic [2:0]               w_funct3;
    logic [6:0]               w_funct7;
    logic                     w_is_shift;
    logic [DATA_WIDTH-1:0]    w_imm_i;
    logic [DATA_WIDTH-1:0]    w_imm_s;
    logic [DATA_WIDTH-1:0]    w_imm_u;
    logic [DATA_WIDTH-1:0]    w_a;
    logic [DATA_WIDTH-1:0]    w_b;
    ALU_Ops                   w_op;
    logic                     w_illegal;

    // funct3 -> ALU op. 'alt' is ir[30]; SUB only exists for register ops.
    function automatic ALU_Ops funct3_op(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
        ALU_Ops op;
        unique case (f3)
            3'b000: op = (alt && allow_sub) ? SubOp : AddOp;
            3'b001: op = SllOp;
            3'b010: op = SltOp;
            3'b011: op = SltuOp;
            3'b100: op = XorOp;
            3'b101: op = alt ? SraOp : SrlOp;
            3'b110: op = OrOp;
            3'b111: op = AndOp;
        endcase
        return op;
    endfunction

    assign w_rs1_idx = r_ir[15 +: RF_ADDR_WIDTH];
    assign w_rs2_idx = r_ir[20 +: RF_ADDR_WIDTH];

`ifdef OPERAND_FWD_EN
    // A write-back landing in the same cycle wins over stale register file data.
    assign w_rs1_src = (wb_en_i && (wb_addr_i != '0) && (wb_addr_i == w_rs1_idx)) ?
                       wb_data_i : rf_data1_i;
    assign w_rs2_src = (wb_en_i && (wb_addr_i != '0) && (wb_addr_i == w_rs2_idx)) ?
                       wb_data_i : rf_data2_i;
`else
    assign w_rs1_src = rf_data1_i;
    assign w_rs2_src = rf_data2_i;
`endif

    // x0 is hardwired to zero regardless of what the register file returns.
    assign w_rs1 = (w_rs1_idx == '0) ? '0 : w_rs1_src;
    assign w_rs2 = (w_rs2_idx == '0) ? '0 : w_rs2_src;

    assign w_opcode   = r_ir[6:0];
    assign w_funct3   = r_ir[14:12];
    assign w_funct7   = r_ir[31:25];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    assign w_imm_i = DATA_WIDTH'($signed(r_ir[31:20]));
    assign w_imm_s = DATA_WIDTH'($signed({r_ir[31:25], r_ir[11:7]}));
    assign w_imm_u = DATA_WIDTH'($signed({r_ir[31:12], 12'b0}));

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_op      = AddOp;
        w_illegal = 1'b0;
        case (w_opcode)
            OpcOp: begin
                if ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000)) begin
                    w_a  = w_rs1;
                    w_b  = w_is_shift ? DATA_WIDTH'(w_rs2[4:0]) : w_rs2;
                    w_op = funct3_op(w_funct3, r_ir[30], 1'b1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                w_a  = w_rs1;
                w_b  = w_is_shift ? DATA_WIDTH'(r_ir[24:20]) : w_imm_i;
                w_op = funct3_op(w_funct3, r_ir[30], 1'b0);
            end
            OpcLui: begin
                w_b = w_imm_u;
            end
            OpcAuipc: begin
                w_a = r_pc;
                w_b = w_imm_u;
            end
            OpcLoad, OpcJalr: begin
                w_a = w_rs1;
                w_b = w_imm_i;
            end
            OpcStore: begin
                w_a = w_rs1;
                w_b = w_imm_s;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // READ spans two cycles: the strobe cycle (r_rd_en high) and the cycle in
    // which the synchronous register file presents its data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= StIdle;
            r_ir       <= '0;
            r_pc       <= '0;
            r_rd_en    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= AddOp;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
            r_op_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (valid_i) begin
                        r_ir    <= ir_i;
                        r_pc    <= pc_i;
                        r_rd_en <= 1'b1;
                        r_state <= StRead;
                    end
                end
                StRead: begin
                    if (r_rd_en) begin
                        r_rd_en <= 1'b0;
                    end else begin
                        r_a        <= w_a;
                        r_b        <= w_b;
                        r_op       <= w_op;
                        r_rd       <= r_ir[7 +: RF_ADDR_WIDTH];
                        r_illegal  <= w_illegal;
                        r_op_valid <= 1'b1;
                        r_state    <= StHold;
                    end
                end
                StHold: begin
                    if (op_ready_i) begin
                        r_op_valid <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ready_o    = (r_state == StIdle) && !reset_i;
    assign rf_rd_en_o = r_rd_en;
    assign rf_rs1_o   = w_rs1_idx;
    assign rf_rs2_o   = w_rs2_idx;
    assign a_o        = r_a;
    assign b_o        = r_b;
    assign func_op_o  = r_op;
    assign rd_o       = r_rd;
    assign illegal_o  = r_illegal;
    assign op_valid_o = r_op_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage. A behavioural RISC-V decode model
// predicts operands for every accepted instruction; a compare process checks
// the DUT against that prediction on every cycle, together with handshake
// timing. Directed instructions with hand-computed results pin the model.
// ============================================================================

module tb_alu_operand_stage;
    import alu_operand_pkg::*;

    logic        clk;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] ir_i;
    logic [31:0] pc_i;
    logic        rf_rd_en_o;
    logic [4:0]  rf_rs1_o;
    logic [4:0]  rf_rs2_o;
    logic [31:0] rf_data1_i;
    logic [31:0] rf_data2_i;
    logic [31:0] a_o;
    logic [31:0] b_o;
    ALU_Ops      func_op_o;
    logic [4:0]  rd_o;
    logic        illegal_o;
    logic        op_valid_o;
    logic        op_ready_i;

    alu_operand_stage #(
        .DATA_WIDTH    (32),
        .RF_ADDR_WIDTH (5)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ir_i       (ir_i),
        .pc_i       (pc_i),
        .rf_rd_en_o (rf_rd_en_o),
        .rf_rs1_o   (rf_rs1_o),
        .rf_rs2_o   (rf_rs2_o),
        .rf_data1_i (rf_data1_i),
        .rf_data2_i (rf_data2_i),
`ifdef OPERAND_FWD_EN
        .wb_en_i    (1'b0),
        .wb_addr_i  (5'd0),
        .wb_data_i  (32'd0),
`endif
        .a_o        (a_o),
        .b_o        (b_o),
        .func_op_o  (func_op_o),
        .rd_o       (rd_o),
        .illegal_o  (illegal_o),
        .op_valid_o (op_valid_o),
        .op_ready_i (op_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        ALU_Ops      op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic [31:0] regs [32];
    exp_t        exp_q [$];
    int          acc_q [$];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] last_a;
    logic [31:0] last_b;
    ALU_Ops      last_op;
    logic [4:0]  last_rd;
    logic        last_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural decode straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] v1;
        logic [31:0] v2;
        int unsigned f3;
        ALU_Ops      tbl [8];
        tbl  = '{AddOp, SllOp, SltOp, SltuOp, XorOp, SrlOp, OrOp, AndOp};
        v1   = (ir[19:15] == 5'd0) ? 32'd0 : regs[ir[19:15]];
        v2   = (ir[24:20] == 5'd0) ? 32'd0 : regs[ir[24:20]];
        f3   = int'(ir[14:12]);
        e.a  = 32'd0;
        e.b  = 32'd0;
        e.op = AddOp;
        e.rd = ir[11:7];
        e.ill = 1'b0;
        case (ir[6:0])
            7'h33: begin
                if (ir[31:25] == 7'h00 || ir[31:25] == 7'h20) begin
                    e.a  = v1;
                    e.b  = (f3 == 1 || f3 == 5) ? (v2 % 32) : v2;
                    e.op = tbl[f3];
                    if (f3 == 0 && ir[30]) e.op = SubOp;
                    if (f3 == 5 && ir[30]) e.op = SraOp;
                end else begin
                    e.ill = 1'b1;
                end
            end
            7'h13: begin
                e.a  = v1;
                e.b  = (f3 == 1 || f3 == 5) ? 32'(ir[24:20]) : 32'($signed(ir[31:20]));
                e.op = tbl[f3];
                if (f3 == 5 && ir[30]) e.op = SraOp;
            end
            7'h37: e.b = ir & 32'hFFFF_F000;
            7'h17: begin
                e.a = pc;
                e.b = ir & 32'hFFFF_F000;
            end
            7'h03, 7'h67: begin
                e.a = v1;
                e.b = 32'($signed(ir[31:20]));
            end
            7'h23: begin
                e.a = v1;
                e.b = 32'($signed({ir[31:25], ir[11:7]}));
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Synchronous-read register file; data is meaningful only one cycle after the strobe.
    always @(posedge clk) begin
        rf_data1_i <= rf_rd_en_o ? regs[rf_rs1_o] : $urandom;
        rf_data2_i <= rf_rd_en_o ? regs[rf_rs2_o] : $urandom;
    end

    // Acceptance / retirement monitor.
    initial begin
        forever begin
            @(posedge clk);
            if (reset_i) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (valid_i && ready_o) begin
                    exp_q.push_back(model(ir_i, pc_i));
                    acc_q.push_back(cyc);
                end
                if (op_valid_o && op_ready_i && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle compare against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (exp_q.size() > 0) begin
                    if (cyc < acc_q[0] + 3) begin
                        chk("valid_too_early", 32'(op_valid_o), 32'd0);
                    end else begin
                        chk("valid_latency", 32'(op_valid_o), 32'd1);
                    end
                    if (op_valid_o) begin
                        e = exp_q[0];
                        chk("a_o", a_o, e.a);
                        chk("b_o", b_o, e.b);
                        chk("func_op_o", 32'(func_op_o), 32'(e.op));
                        chk("rd_o", 32'(rd_o), 32'(e.rd));
                        chk("illegal_o", 32'(illegal_o), 32'(e.ill));
                        chk("ready_busy", 32'(ready_o), 32'd0);
                    end
                end else begin
                    chk("idle_no_valid", 32'(op_valid_o), 32'd0);
                end
            end
        end
    end

    task automatic run_txn(input logic [31:0] ir, input logic [31:0] pc, input int hold);
        int n;
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        ir_i    = ir;
        pc_i    = pc;
        @(negedge clk);
        n = 0;
        // Junk on the request side and early op_ready_i must both be ignored.
        while (!op_valid_o && n < 10) begin
            valid_i    = 1'($urandom);
            ir_i       = $urandom;
            pc_i       = $urandom;
            op_ready_i = 1'($urandom);
            @(negedge clk);
            n++;
        end
        chk("valid_wait", 32'(op_valid_o), 32'd1);
        last_a   = a_o;
        last_b   = b_o;
        last_op  = func_op_o;
        last_rd  = rd_o;
        last_ill = illegal_o;
        op_ready_i = 1'b0;
        repeat (hold) begin
            valid_i = 1'($urandom);
            ir_i    = $urandom;
            @(negedge clk);
        end
        op_ready_i = 1'b1;
        @(negedge clk);
        op_ready_i = 1'b0;
        valid_i    = 1'b0;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        logic [6:0]  opc [7];
        int          k;
        opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h67, 7'h23};
        r   = $urandom;
        k   = $urandom_range(0, 8);
        if (k < 7) r[6:0] = opc[k];
        if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) r[19:15] = 5'd0;
        if ($urandom_range(0, 7) == 0) r[24:20] = 5'd0;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0]    = 32'hDEAD_BEEF;
        reset_i    = 1'b1;
        valid_i    = 1'b0;
        ir_i       = 32'd0;
        pc_i       = 32'd0;
        op_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(op_valid_o), 32'd0);
        chk("rst_rd_en", 32'(rf_rd_en_o), 32'd0);
        chk("rst_a", a_o, 32'd0);
        chk("rst_b", b_o, 32'd0);
        chk("rst_op", 32'(func_op_o), 32'(AddOp));
        chk("rst_ill", 32'(illegal_o), 32'd0);
        reset_i = 1'b0;
        #1;
        chk("rst_release_ready", 32'(ready_o), 32'd1);
        @(negedge clk);

        // ADD x3,x1,x2
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        run_txn(32'h0020_81B3, 32'h0, 0);
        chk("add_a", last_a, 32'd5);
        chk("add_b", last_b, 32'd7);
        chk("add_op", 32'(last_op), 32'(AddOp));
        chk("add_rd", 32'(last_rd), 32'd3);
        chk("add_ill", 32'(last_ill), 32'd0);
        // SUB x3,x1,x2
        run_txn(32'h4020_81B3, 32'h0, 1);
        chk("sub_op", 32'(last_op), 32'(SubOp));
        // SRAI x5,x1,4
        regs[1] = 32'h8000_0000;
        run_txn(32'h4040_D293, 32'h0, 0);
        chk("srai_op", 32'(last_op), 32'(SraOp));
        chk("srai_a", last_a, 32'h8000_0000);
        chk("srai_b", last_b, 32'd4);
        chk("srai_rd", 32'(last_rd), 32'd5);
        // SLL x4,x1,x2 with x2=0x123
        regs[2] = 32'h0000_0123;
        run_txn(32'h0020_9233, 32'h0, 0);
        chk("sll_op", 32'(last_op), 32'(SllOp));
        chk("sll_b", last_b, 32'd3);
        // ADDI x1,x0,-1 (x0 holds garbage in the RF model)
        run_txn(32'hFFF0_0093, 32'h0, 0);
        chk("addi_a", last_a, 32'd0);
        chk("addi_b", last_b, 32'hFFFF_FFFF);
        chk("addi_op", 32'(last_op), 32'(AddOp));
        // LUI x7,0x12345
        run_txn(32'h1234_53B7, 32'h0, 0);
        chk("lui_a", last_a, 32'd0);
        chk("lui_b", last_b, 32'h1234_5000);
        chk("lui_rd", 32'(last_rd), 32'd7);
        // AUIPC x1,0x1 at pc 0x100
        run_txn(32'h0000_1097, 32'h100, 0);
        chk("auipc_a", last_a, 32'h100);
        chk("auipc_b", last_b, 32'h1000);
        // Illegal opcode, held for 3 cycles
        run_txn(32'h0000_007F, 32'h0, 3);
        chk("illegal_flag", 32'(last_ill), 32'd1);
        chk("illegal_a", last_a, 32'd0);
        chk("illegal_b", last_b, 32'd0);

        // Reset asserted while HOLD
        regs[1] = 32'd11;
        valid_i = 1'b1;
        ir_i    = 32'h0020_81B3;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !op_valid_o; i++) @(negedge clk);
        chk("hold_reached", 32'(op_valid_o), 32'd1);
        reset_i = 1'b1;
        #1;
        chk("hold_rst_valid", 32'(op_valid_o), 32'd0);
        chk("hold_rst_a", a_o, 32'd0);
        chk("hold_rst_b", b_o, 32'd0);
        chk("hold_rst_op", 32'(func_op_o), 32'(AddOp));
        chk("hold_rst_rd", 32'(rd_o), 32'd0);
        chk("hold_rst_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);

        // Randomised traffic
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 1; i < 32; i++) regs[i] = $urandom;
            end
            run_txn(rand_ir(), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
